// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and the
// parity helper used by the transmitter (and the companion receiver).
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity of a zero-extended word; odd=1 inverts the even-parity result.
    function automatic logic parity_bit(input logic [15:0] data, input logic odd);
        parity_bit = (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DBIT data bits LSB-first, optional
// parity bit, SB_TICK-tick stop bit, paced by a 16x oversampling s_tick.
// Optional parity bit is built in when the macro UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    localparam int TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int BIT_W    = $clog2(DBIT + 1);

    localparam logic [TICK_W-1:0] TICK_ZERO      = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO       = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE        = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DBIT - 1);

    // Reject unsupported configurations at elaboration time.
    if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
        $error("uart_tx_serializer: DBIT must be 5..9");
    end
    if (SB_TICK < OVERSAMPLE) begin : g_bad_sb_tick
        $error("uart_tx_serializer: SB_TICK must be at least 16");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    uart_state_e       state_r, state_n;
    logic [TICK_W-1:0] tick_r, tick_n;
    logic [BIT_W-1:0]  bit_r, bit_n;
    logic [DBIT-1:0]   shift_r, shift_n;
    logic              tx_r, tx_n;
    logic              busy_r;
    logic              done_s;
`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    logic par_r, par_n;
`endif

    // Next-state, counter and shift-register logic; done_s marks the last stop tick.
    always_comb begin
        state_n = state_r;
        tick_n  = tick_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (tx_start) begin
                    state_n = START;
                    tick_n  = TICK_ZERO;
                    shift_n = tx_din;
`ifdef UART_TX_PARITY_EN
                    par_n   = parity_bit({{(16 - DBIT){1'b0}}, tx_din}, ODD_BIT);
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_r == TICK_BIT_LAST) begin
                        state_n = DATA;
                        tick_n  = TICK_ZERO;
                        bit_n   = BIT_ZERO;
                    end else begin
                        tick_n = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_n = tick_r;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_r == TICK_BIT_LAST) begin
                        tick_n  = TICK_ZERO;
                        shift_n = {1'b0, shift_r[DBIT-1:1]};
                        bit_n   = bit_r + BIT_ONE;
                        if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            state_n = DATA;
                        end
                    end else begin
                        tick_n = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_n = tick_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_r == TICK_BIT_LAST) begin
                        state_n = STOP;
                        tick_n  = TICK_ZERO;
                    end else begin
                        tick_n = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_n = tick_r;
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_r == TICK_STOP_LAST) begin
                        state_n = IDLE;
                        tick_n  = TICK_ZERO;
                        done_s  = 1'b1;
                    end else begin
                        tick_n = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_n = tick_r;
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = TICK_ZERO;
                bit_n   = BIT_ZERO;
            end
        endcase
    end

    // Line level for the state being entered, so tx tracks state with no extra cycle.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            IDLE:   tx_n = 1'b1;
            START:  tx_n = 1'b0;
            DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = par_n;
`endif
            STOP:   tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line/busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DBIT{1'b0}};
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            tick_r  <= tick_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
            busy_r  <= (state_n != IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted word, held for the whole frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_n;
        end
    end
`endif

    // The done strobe is decoded from registered state in the final stop-tick
    // cycle, so the FIFO pops on the same edge the FSM returns to IDLE and the
    // next word is already presented when IDLE samples tx_start.
    assign tx_done_tick = done_s;
    assign tx_busy      = busy_r;
    assign tx           = tx_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level model (bit list
// plus tick position) is compared with the DUT every clock, plus directed
// literal checks of line sequences, frame length and reset behaviour.
module tb_uart_tx_serializer;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int PODD    = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS       = 1 + DBIT + PAR + 1;
    localparam int FRAME_TICKS = 16 * (1 + DBIT + PAR) + SB_TICK;
    localparam int LIT_FRAME   = (PAR != 0) ? 176 : 160;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            tx_start = 1'b0;
    logic            s_tick = 1'b0;
    logic [DBIT-1:0] tx_din = '0;
    logic            tx_done_tick;
    logic            tx_busy;
    logic            tx;

    uart_tx_serializer #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(PODD)) dut (
        .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .s_tick(s_tick),
        .tx_din(tx_din), .tx_done_tick(tx_done_tick), .tx_busy(tx_busy), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame as a list of line levels: start, data LSB-first, parity, stop.
    function automatic logic [15:0] build_frame(input logic [DBIT-1:0] d);
        logic [15:0] f;
        int ones;
        f = 16'hFFFF;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < DBIT; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (PAR != 0) f[1+DBIT] = ((ones % 2) != PODD);
        return f;
    endfunction

    // s_tick generator: 0 = off, 1 = periodic, 2 = random density
    int tick_mode = 0;
    int tick_period = 4;
    int tick_pct = 50;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                1: begin
                    s_tick = (ph == 0);
                    ph = (ph + 1) % tick_period;
                end
                2: s_tick = ($urandom_range(99) < tick_pct);
                default: s_tick = 1'b0;
            endcase
        end
    end

    // model state
    bit          m_active = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_frame = 16'hFFFF;
    // recorder of DUT behaviour for directed checks
    int   rec_ticks = 0;
    logic rec_q[$];
    int   done_cnt = 0;
    int   done_ticks = 0;
    int   idle_run = 0;
    int   last_gap = -1;
    bit   prev_busy = 1'b0;

    // Per-cycle compare against the model, recording, then model advance.
    always @(negedge clk) begin
        logic e_tx, e_done;
        int idx;
        if (!reset_n) begin
            m_active = 1'b0;
            rec_ticks = 0;
            prev_busy = 1'b0;
        end else begin
            idx = m_pos / 16;
            e_tx = !m_active ? 1'b1 : ((idx >= NBITS - 1) ? 1'b1 : m_frame[idx]);
            e_done = m_active && s_tick && (m_pos == FRAME_TICKS - 1);
            chk("model_tx", tx, e_tx);
            chk("model_busy", tx_busy, m_active);
            chk("model_done", tx_done_tick, e_done);

            if (tx_busy && !prev_busy) begin
                rec_q.delete();
                rec_ticks = 0;
                last_gap = idle_run;
            end
            if (tx_busy) idle_run = 0; else idle_run++;
            if (tx_busy && s_tick) begin
                if ((rec_ticks % 16) == 8 && rec_q.size() < NBITS) rec_q.push_back(tx);
                rec_ticks++;
            end
            if (tx_done_tick) begin
                done_cnt++;
                done_ticks = rec_ticks;
            end
            prev_busy = tx_busy;

            if (!m_active) begin
                if (tx_start) begin
                    m_active = 1'b1;
                    m_pos = 0;
                    m_frame = build_frame(tx_din);
                end
            end else if (s_tick) begin
                if (m_pos == FRAME_TICKS - 1) m_active = 1'b0;
                else m_pos++;
            end
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, done_cnt, target);
    endtask

    task automatic send_pulse(input logic [DBIT-1:0] d);
        tx_din = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    initial begin
        int d0;
        int n;
        logic [9:0] lit_a5;
        logic [7:0] lit_c3;
        logic [15:0] mf;
        lit_a5 = 10'b1101001010;
        lit_c3 = 8'b11000011;

        // pin the model's frame builder to a hand-computed line sequence
        mf = build_frame(8'hA5);
        chk("model_pin_a5", {23'd0, mf[8:0]}, {23'd0, lit_a5[8:0]});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done_tick, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_start", tx_busy, 1'b0);

        // single frame 0xA5, s_tick every 4 clk
        tick_mode = 1;
        tick_period = 4;
        d0 = done_cnt;
        send_pulse(8'hA5);
        wait_done(d0 + 1, 4 * FRAME_TICKS + 100, "a5_done");
        for (int i = 0; i < 9; i++) chk("a5_line_bit", rec_q[i], lit_a5[i]);
        chk("a5_stop_bit", rec_q[NBITS-1], 1'b1);
        chk("a5_frame_ticks", done_ticks, LIT_FRAME);
        chk("a5_frame_formula", done_ticks, FRAME_TICKS);
        repeat (100) @(posedge clk);
        #1;
        chk("a5_one_done", done_cnt, d0 + 1);

        // data stability: tx_din changes mid-frame
        tick_period = 2;
        d0 = done_cnt;
        send_pulse(8'hC3);
        repeat (40) @(posedge clk);
        #1;
        tx_din = 8'h3C;
        wait_done(d0 + 1, 2 * FRAME_TICKS + 100, "c3_done");
        for (int i = 0; i < 8; i++) chk("c3_data_bit", rec_q[1+i], lit_c3[i]);

        // back-to-back frames, s_tick every clk, tx_start held high
        tick_period = 1;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        tx_din = 8'h00;
        tx_start = 1'b1;
        n = 0;
        while (done_cnt < d0 + 1 && n < FRAME_TICKS + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tx_din = 8'hFF;
        n = 0;
        while (done_cnt < d0 + 2 && n < FRAME_TICKS + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tx_start = 1'b0;
        chk("b2b_two_done", done_cnt, d0 + 2);
        chk("b2b_gap", last_gap, 1);
        for (int i = 0; i < 8; i++) chk("b2b_ff_bit", rec_q[1+i], 1'b1);
        repeat (5) @(posedge clk);

`ifdef UART_TX_PARITY_EN
        // parity bit for 0x07
        d0 = done_cnt;
        send_pulse(8'h07);
        wait_done(d0 + 1, FRAME_TICKS + 50, "par_done");
        chk("par_bit_07", rec_q[1+DBIT], (PODD != 0) ? 1'b0 : 1'b1);
        chk("par_frame_ticks", done_ticks, 176);
`endif

        // randomized traffic checked every cycle by the model
        tick_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if ((c % 500) == 0) tick_pct = $urandom_range(100, 20);
            tx_start = ($urandom_range(99) < 30);
            tx_din = DBIT'($urandom);
        end
        tx_start = 1'b0;
        tick_mode = 1;
        tick_period = 1;
        n = 0;
        while (tx_busy && n < FRAME_TICKS + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("random_drain", tx_busy, 1'b0);

        // asynchronous reset during data bit 3
        tick_period = 4;
        send_pulse(8'h5A);
        n = 0;
        while (rec_ticks < 16 * 4 + 4 && n < 4 * FRAME_TICKS) begin
            @(posedge clk);
            n++;
        end
        chk("rst_reached_bit3", (rec_ticks >= 16 * 4 + 4), 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1'b1);
        chk("rst_async_busy", tx_busy, 1'b0);
        chk("rst_async_done", tx_done_tick, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("post_rst_idle_tx", tx, 1'b1);
        chk("post_rst_idle_busy", tx_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
